speed_ramp: RTL



---
 rtl/speed_ramp_pkg.sv | 18 +
 rtl/speed_ramp_input_debouncer.sv | 50 +++++
 rtl/speed_ramp.sv | 138 +++++++++++++
 3 files changed

// File: rtl/speed_ramp_pkg.sv
// Shared types and constants for the speed_ramp command stage.
package speed_ramp_pkg;

  localparam int SPEED_W_DEF = 3;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    HOLD      = 2'd1,
    RAMP_UP   = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/speed_ramp_input_debouncer.sv
// Synchronizes an asynchronous bus and accepts a new value only after it
// has been stable for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer
  import speed_ramp_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  cand;
  logic [DB_W-1:0]                   db_cnt;
  logic [WIDTH-1:0]                  din_s;

  assign din_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // The counter saturates at DB_LAST so a stable input keeps reloading dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= '0;
      db_cnt <= '0;
      dout   <= '0;
    end else if (din_s != cand) begin
      cand   <= din_s;
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      dout <= cand;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/speed_ramp.sv
// Command stage for the PWM generator: debounces the speed switches and
// ramps the speed code one step per STEP_CYCLES, with soft stop on disable.
module speed_ramp
  import speed_ramp_pkg::*;
#(
  parameter int SPEED_W         = SPEED_W_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STEP_CYCLES     = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] target_in,
  input  logic               enable_in,
  output logic [SPEED_W-1:0] speed_out,
  output logic               enable_out,
  output logic               ramping,
  output logic               at_target
);

  localparam int STEP_W = cnt_width(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  ramp_state_t            state;
  logic [STEP_W-1:0]      step_cnt;
  logic [SYNC_STAGES-1:0] enable_sync;
  logic                   enable_s;
  logic [SPEED_W-1:0]     tgt_q;
  logic [SPEED_W-1:0]     goal;
  logic [SPEED_W-1:0]     speed_inc;
  logic [SPEED_W-1:0]     speed_dec;

  input_debouncer #(
    .WIDTH          (SPEED_W),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_target_db (
    .clk (clk),
    .rst (rst),
    .din (target_in),
    .dout(tgt_q)
  );

  // Enable is only synchronized; the ramp itself filters its effect on duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_sync <= '0;
    end else begin
      enable_sync <= {enable_sync[SYNC_STAGES-2:0], enable_in};
    end
  end

  assign enable_s  = enable_sync[SYNC_STAGES-1];
  assign goal      = enable_s ? tgt_q : '0;
  assign speed_inc = speed_out + SPEED_W'(1);
  assign speed_dec = speed_out - SPEED_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      speed_out  <= '0;
      enable_out <= 1'b0;
      ramping    <= 1'b0;
      at_target  <= 1'b0;
      step_cnt   <= '0;
    end else begin
      case (state)
        OFF: begin
          if (enable_s) begin
            state      <= HOLD;
            enable_out <= 1'b1;
            at_target  <= 1'b1;
          end
        end
        HOLD: begin
          if (goal > speed_out) begin
            state     <= RAMP_UP;
            ramping   <= 1'b1;
            at_target <= 1'b0;
            step_cnt  <= '0;
          end else if (goal < speed_out) begin
            state     <= RAMP_DOWN;
            ramping   <= 1'b1;
            at_target <= 1'b0;
            step_cnt  <= '0;
          end else if (!enable_s && speed_out == '0) begin
            state      <= OFF;
            enable_out <= 1'b0;
            at_target  <= 1'b0;
          end
        end
        RAMP_UP: begin
          // Goal changes take priority over the pending step.
          if (goal == speed_out) begin
            state     <= HOLD;
            ramping   <= 1'b0;
            at_target <= 1'b1;
          end else if (goal < speed_out) begin
            state    <= RAMP_DOWN;
            step_cnt <= '0;
          end else if (step_cnt == STEP_LAST) begin
            speed_out <= speed_inc;
            step_cnt  <= '0;
            if (speed_inc == goal) begin
              state     <= HOLD;
              ramping   <= 1'b0;
              at_target <= 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end
        RAMP_DOWN: begin
          if (goal == speed_out) begin
            state     <= HOLD;
            ramping   <= 1'b0;
            at_target <= 1'b1;
          end else if (goal > speed_out) begin
            state    <= RAMP_UP;
            step_cnt <= '0;
          end else if (step_cnt == STEP_LAST) begin
            speed_out <= speed_dec;
            step_cnt  <= '0;
            if (speed_dec == goal) begin
              state     <= HOLD;
              ramping   <= 1'b0;
              at_target <= 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule
